// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, data width
// and parity mode. Optional parity support is selected by the macro
// UART_RX_PARITY_EN (undefined: 8N1 framing, defined: 8E1 framing).
package uart_pkg;

    localparam int DATA_BITS = 8;

`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // 0 = even parity: data bits plus parity bit carry an even number of ones.
    localparam bit PARITY_ODD = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // High when the received parity bit disagrees with the data.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] data,
                                        input logic par);
        return (^data) ^ par ^ PARITY_ODD;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports: clk/rst (async active-high), d (async in), q (synchronized out).
// Latency 2 cycles; both flops take RST_VAL on reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 8 data bits LSB first, 1 stop bit, optional even parity
// (macro UART_RX_PARITY_EN). One-entry output holding register with
// valid/ready handshake; a byte completing while the register is still full
// and not being accepted is dropped and flagged on overrun_o.
// Ports: clk, rst (async active-high), rx_i (serial line), rx_data_o/
// rx_valid_o/rx_ready_i (byte handshake), frame_err_o/overrun_o/parity_err_o
// (one-cycle pulses), busy_o (frame in progress).
// Latency: falling edge of start bit to rx_valid_o = 3 + CLKS_PER_BIT/2 +
// 9*CLKS_PER_BIT cycles (+CLKS_PER_BIT with parity).
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o,
    output logic       busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    logic                 rx_sync;
    logic                 rx_prev;
    uart_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_i),
        .q   (rx_sync)
    );

    assign busy_o = (state != ST_IDLE);

`ifndef UART_RX_PARITY_EN
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rx_prev     <= 1'b1;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            rx_data_o   <= 8'h00;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            parity_err_o <= 1'b0;
`endif
        end else begin
            // rx_prev tracks the line in every state so a line held low
            // (break, or a low stop bit) never looks like a fresh start edge.
            rx_prev     <= rx_sync;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
            if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= ST_START;
                        cnt   <= HALF_LOAD;
                    end
                end

                // Re-check the start bit at its centre to reject glitches.
                ST_START: begin
                    if (cnt == '0) begin
                        if (rx_sync) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DATA;
                            cnt     <= BIT_LOAD;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_DATA: begin
                    if (cnt == '0) begin
                        shift <= {rx_sync, shift[DATA_BITS-1:1]};
                        cnt   <= BIT_LOAD;
                        if (bit_idx == LAST_IDX) begin
                            state <= PARITY_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (cnt == '0) begin
                        par_bit <= rx_sync;
                        cnt     <= BIT_LOAD;
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
`else
                    state <= ST_IDLE;
`endif
                end

                // Decide at mid-stop-bit and return to IDLE right away so the
                // next start edge can follow the stop bit directly.
                ST_STOP: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        if (!rx_sync) begin
                            frame_err_o <= 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        else if (parity_bad(shift, par_bit)) begin
                            parity_err_o <= 1'b1;
                        end
`endif
                        else if (rx_valid_o && !rx_ready_i) begin
                            overrun_o <= 1'b1;
                        end else begin
                            rx_data_o  <= shift;
                            rx_valid_o <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1 + CPB;
`else
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       parity_err_o;
    logic       busy_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .parity_err_o (parity_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: observed handshakes and pulses, stamped with the cycle number.
    int         got_cyc[$];
    logic [7:0] got_dat[$];
    int         fe_cyc[$];
    int         ov_cyc[$];
    int         pe_cnt;
    int         v_cnt;
    int         busy_cnt;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid_o && rx_ready_i) begin
                got_cyc.push_back(cyc);
                got_dat.push_back(rx_data_o);
            end
            if (frame_err_o) fe_cyc.push_back(cyc);
            if (overrun_o)   ov_cyc.push_back(cyc);
            if (parity_err_o) pe_cnt++;
            if (rx_valid_o)   v_cnt++;
            if (busy_o)       busy_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        got_cyc.delete();
        got_dat.delete();
        fe_cyc.delete();
        ov_cyc.delete();
        pe_cnt   = 0;
        v_cnt    = 0;
        busy_cnt = 0;
    endtask

    // Drives one frame starting right after a clock edge; c0 is that cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par_flip, input logic hold_low,
                              output int c0);
        c0   = cyc;
        rx_i = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            repeat (CPB) tick();
        end
`ifdef UART_RX_PARITY_EN
        rx_i = (^d) ^ par_flip;
        repeat (CPB) tick();
`else
        if (par_flip) rx_i = 1'b1;
`endif
        rx_i = stop;
        repeat (CPB) tick();
        if (!hold_low) rx_i = 1'b1;
    endtask

    // Expected outcome of the random phase, built from framing rules only.
    int         exp_cyc[$];
    logic [7:0] exp_dat[$];
    int         exp_fe[$];

    initial begin
        int         c0, c1;
        logic [7:0] d;
        logic       stop;
        int         g;

        rst        = 1'b1;
        rx_i       = 1'b1;
        rx_ready_i = 1'b1;
        clr_mon();
        repeat (3) tick();
        chk("rst_valid", rx_valid_o, 0);
        chk("rst_data",  rx_data_o, 8'h00);
        chk("rst_busy",  busy_o, 0);
        chk("rst_pulses", {frame_err_o, overrun_o, parity_err_o}, 0);
        rst = 1'b0;
        repeat (5) tick();

        // Clean byte, consumer always ready.
        clr_mon();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, c0);
        repeat (10) tick();
        chk("a5_count", got_dat.size(), 1);
        chk("a5_data",  (got_dat.size() > 0) ? got_dat[0] : 8'hxx, 8'hA5);
        chk("a5_cycle", (got_cyc.size() > 0) ? got_cyc[0] : -1, c0 + LAT);
        chk("a5_vwidth", v_cnt, 1);
        chk("a5_errs", fe_cyc.size() + ov_cyc.size() + pe_cnt, 0);

        // Short low glitch is rejected at the start-bit centre.
        clr_mon();
        c0   = cyc;
        rx_i = 1'b0;
        repeat (4) tick();
        rx_i = 1'b1;
        tick();
        chk("glitch_busy_mid", busy_o, 1);
        while (cyc < c0 + 11) tick();
        chk("glitch_busy_end", busy_o, 0);
        repeat (CPB * 12) tick();
        chk("glitch_events", got_dat.size() + fe_cyc.size() + pe_cnt + v_cnt, 0);

        // Low stop bit, then the line stays low (break).
        clr_mon();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, c0);
        chk("fe_count", fe_cyc.size(), 1);
        chk("fe_cycle", (fe_cyc.size() > 0) ? fe_cyc[0] : -1, c0 + LAT);
        chk("fe_novalid", v_cnt, 0);
        clr_mon();
        repeat (200) tick();
        chk("break_busy", busy_cnt, 0);
        rx_i = 1'b1;
        repeat (20) tick();
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, c0);
        repeat (10) tick();
        chk("after_break", (got_dat.size() == 1) ? got_dat[0] : 8'hxx, 8'h5A);

        // Back-to-back frames with the consumer stalled.
        clr_mon();
        rx_ready_i = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, c0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, c1);
        repeat (10) tick();
        chk("ovr_held_data", rx_data_o, 8'h11);
        chk("ovr_valid", rx_valid_o, 1);
        chk("ovr_count", ov_cyc.size(), 1);
        chk("ovr_cycle", (ov_cyc.size() > 0) ? ov_cyc[0] : -1, c1 + LAT);
        rx_ready_i = 1'b1;
        tick();
        chk("ovr_accept_data", (got_dat.size() == 1) ? got_dat[0] : 8'hxx, 8'h11);
        chk("ovr_valid_fall", rx_valid_o, 0);

        // Reset in the middle of data bit 4.
        clr_mon();
        d    = 8'h7E;
        rx_i = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            rx_i = d[i];
            repeat (CPB) tick();
        end
        rx_i = d[4];
        repeat (CPB / 2) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_data", rx_data_o, 8'h00);
        rx_i = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, c0);
        repeat (10) tick();
        chk("mid_rst_count", got_dat.size(), 1);
        chk("mid_rst_byte", (got_dat.size() > 0) ? got_dat[0] : 8'hxx, 8'h81);

`ifdef UART_RX_PARITY_EN
        clr_mon();
        send_frame(8'h03, 1'b1, 1'b1, 1'b0, c0);
        repeat (10) tick();
        chk("par_bad_pulse", pe_cnt, 1);
        chk("par_bad_nodeliver", v_cnt, 0);
        clr_mon();
        send_frame(8'h03, 1'b1, 1'b0, 1'b0, c0);
        repeat (10) tick();
        chk("par_ok_data", (got_dat.size() == 1) ? got_dat[0] : 8'hxx, 8'h03);
        chk("par_ok_cycle", (got_cyc.size() > 0) ? got_cyc[0] : -1, c0 + 171);
`endif

        // Random frames, random gaps, occasional bad stop bit.
        clr_mon();
        exp_cyc.delete();
        exp_dat.delete();
        exp_fe.delete();
        for (int n = 0; n < 30; n++) begin
            g = $urandom_range(1, 20);
            repeat (g) tick();
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, stop, 1'b0, 1'b0, c0);
            if (stop) begin
                exp_cyc.push_back(c0 + LAT);
                exp_dat.push_back(d);
            end else begin
                exp_fe.push_back(c0 + LAT);
            end
        end
        repeat (20) tick();
        chk("rnd_count", got_dat.size(), exp_dat.size());
        chk("rnd_fe_count", fe_cyc.size(), exp_fe.size());
        for (int i = 0; i < exp_dat.size(); i++) begin
            chk("rnd_data", (i < got_dat.size()) ? got_dat[i] : 8'hxx, exp_dat[i]);
            chk("rnd_cycle", (i < got_cyc.size()) ? got_cyc[i] : -1, exp_cyc[i]);
        end
        for (int i = 0; i < exp_fe.size(); i++) begin
            chk("rnd_fe_cycle", (i < fe_cyc.size()) ? fe_cyc[i] : -1, exp_fe[i]);
        end
        chk("rnd_overrun", ov_cyc.size(), 0);
        chk("rnd_parity", pe_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
